// File: rtl/key_press_gen.sv
// Key press generator: drives an active-low key line with
// short or long presses, optionally repeated with gaps.
module key_press_gen #(
  parameter int unsigned      CNT_W        = 25,
  parameter logic [CNT_W-1:0] SHORT_CYCLES = 25'h00F4240,
  parameter logic [CNT_W-1:0] LONG_CYCLES  = 25'h0A98AC7,
  parameter logic [CNT_W-1:0] GAP_CYCLES   = 25'h04C4B40
) (
  input  logic       FPGA_clk,
  input  logic       FPGA_rst,
  input  logic       start,
  input  logic       long_sel,
  input  logic [3:0] repeat_n,
  input  logic       abort,
  output logic       KEY_N,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Counter reload values: a duration of 0 behaves as 1 clock
  localparam logic [CNT_W-1:0] SHORT_LD =
    (SHORT_CYCLES == '0) ? '0 : SHORT_CYCLES - ONE;
  localparam logic [CNT_W-1:0] LONG_LD =
    (LONG_CYCLES == '0) ? '0 : LONG_CYCLES - ONE;
  localparam logic [CNT_W-1:0] GAP_LD =
    (GAP_CYCLES == '0) ? '0 : GAP_CYCLES - ONE;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       rep_q, rep_d;
  logic             long_q, long_d;
  logic             key_q, key_d;
  logic             done_q, done_d;
  logic             ab_q, ab_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [3:0]       pcnt_inc;

  assign pcnt_inc = pcnt_q + 4'd1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rep_d   = rep_q;
    long_d  = long_q;
    key_d   = key_q;
    done_d  = 1'b0;
    ab_d    = 1'b0;
    pcnt_d  = pcnt_q;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        key_d = 1'b1;
        if (start && !abort) begin
          state_d = PRESS;
          rep_d   = (repeat_n == 4'd0) ? 4'd1 : repeat_n;
          long_d  = long_sel;
          pcnt_d  = 4'd0;
          cnt_d   = long_sel ? LONG_LD : SHORT_LD;
          key_d   = 1'b0;
        end
      end
      PRESS: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          key_d   = 1'b1;
          ab_d    = 1'b1;
        end else if (cnt == '0) begin
          pcnt_d = pcnt_inc;
          key_d  = 1'b1;
          if (pcnt_inc == rep_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          key_d   = 1'b1;
          ab_d    = 1'b1;
        end else if (cnt == '0) begin
          state_d = PRESS;
          cnt_d   = long_q ? LONG_LD : SHORT_LD;
          key_d   = 1'b0;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        key_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rep_q  <= 4'd0;
      long_q <= 1'b0;
      key_q  <= 1'b1;
      done_q <= 1'b0;
      ab_q   <= 1'b0;
      pcnt_q <= 4'd0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rep_q  <= rep_d;
      long_q <= long_d;
      key_q  <= key_d;
      done_q <= done_d;
      ab_q   <= ab_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign KEY_N     = key_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign aborted   = ab_q;
  assign press_cnt = pcnt_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen: queue-based expected waveform
// checked every cycle, plus literal per-sequence totals.
module tb_key_press_gen;

  localparam int SHORT = 4;
  localparam int LONG  = 10;
  localparam int GAPC  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       long_sel = 1'b0;
  logic [3:0] repeat_n = 4'd0;
  logic       abort = 1'b0;
  logic       key_n, busy, done, aborted;
  logic [3:0] press_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_press_gen #(
    .CNT_W(8),
    .SHORT_CYCLES(8'd4),
    .LONG_CYCLES(8'd10),
    .GAP_CYCLES(8'd3)
  ) dut (
    .FPGA_clk(clk),
    .FPGA_rst(rst),
    .start(start),
    .long_sel(long_sel),
    .repeat_n(repeat_n),
    .abort(abort),
    .KEY_N(key_n),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .press_cnt(press_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic       key;
    logic       bsy;
    logic       dn;
    logic       ab;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

  // Whole future waveform of a sequence, one entry per clock
  function automatic void build(input logic ls,
                                input logic [3:0] rn);
    int d = ls ? LONG : SHORT;
    int n = (rn == 4'd0) ? 1 : int'(rn);
    for (int k = 1; k <= n; k++) begin
      for (int i = 0; i < d; i++)
        q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'(k - 1)});
      if (k < n)
        for (int i = 0; i < GAPC; i++)
          q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 4'(k)});
    end
    q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4'(n)});
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    end else if (cur.bsy) begin
      if (abort) begin
        q.delete();
        cur = '{1'b1, 1'b0, 1'b0, 1'b1, cur.cnt};
      end else begin
        cur = q.pop_front();
      end
    end else if (start && !abort) begin
      build(long_sel, repeat_n);
      cur = q.pop_front();
    end else begin
      cur = '{1'b1, 1'b0, 1'b0, 1'b0, cur.cnt};
    end
    #1;
    chk("KEY_N", 32'(key_n), 32'(cur.key));
    chk("busy", 32'(busy), 32'(cur.bsy));
    chk("done", 32'(done), 32'(cur.dn));
    chk("aborted", 32'(aborted), 32'(cur.ab));
    chk("press_cnt", 32'(press_cnt), 32'(cur.cnt));
  end

  task automatic run_seq(input logic ls,
                         input logic [3:0] rn,
                         input int ab_at,
                         input int st_at,
                         input int rs_at,
                         output int lows,
                         output int bc);
    @(negedge clk);
    start    = 1'b1;
    long_sel = ls;
    repeat_n = rn;
    lows = 0;
    bc   = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (!busy) break;
      bc++;
      if (!key_n) lows++;
      if (bc == ab_at) abort = 1'b1;
      if (bc == st_at) begin
        start    = 1'b1;
        long_sel = ~ls;
        repeat_n = 4'd7;
      end
      if (bc == rs_at) rst = 1'b1;
    end
    chk("timeout_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lows, bc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_key", 32'(key_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(press_cnt), 32'd0);

    run_seq(1'b0, 4'd1, 0, 0, 0, lows, bc);
    chk("s1_lows", 32'(lows), 32'd4);
    chk("s1_busy", 32'(bc), 32'd4);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_cnt", 32'(press_cnt), 32'd1);

    run_seq(1'b1, 4'd3, 0, 0, 0, lows, bc);
    chk("l3_lows", 32'(lows), 32'd30);
    chk("l3_busy", 32'(bc), 32'd36);
    chk("l3_done", 32'(done), 32'd1);
    chk("l3_cnt", 32'(press_cnt), 32'd3);

    run_seq(1'b0, 4'd0, 0, 2, 0, lows, bc);
    chk("r0_lows", 32'(lows), 32'd4);
    chk("r0_busy", 32'(bc), 32'd4);
    chk("r0_cnt", 32'(press_cnt), 32'd1);

    run_seq(1'b0, 4'd2, 9, 0, 0, lows, bc);
    chk("ab_lows", 32'(lows), 32'd6);
    chk("ab_busy", 32'(bc), 32'd9);
    chk("ab_pulse", 32'(aborted), 32'd1);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_cnt", 32'(press_cnt), 32'd1);
    chk("ab_key", 32'(key_n), 32'd1);

    run_seq(1'b1, 4'd1, 0, 0, 5, lows, bc);
    chk("rs_busy", 32'(bc), 32'd5);
    chk("rs_key", 32'(key_n), 32'd1);
    chk("rs_cnt", 32'(press_cnt), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_ab", 32'(aborted), 32'd0);

    @(negedge clk);
    start    = 1'b1;
    abort    = 1'b1;
    long_sel = 1'b1;
    repeat_n = 4'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_key", 32'(key_n), 32'd1);
      @(negedge clk);
    end

    run_seq(1'b1, 4'd2, 0, 0, 0, lows, bc);
    chk("l2_lows", 32'(lows), 32'd20);
    chk("l2_busy", 32'(bc), 32'd23);
    chk("l2_cnt", 32'(press_cnt), 32'd2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/key_press_gen.md
KEY_PRESS_GEN -- requirements
Module: key_press_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 25, meaning the width of the duration counter.
REQ-002 SHALL have parameter SHORT_CYCLES, default 25'h00F4240, meaning the low time of a short press in clocks.
REQ-003 SHALL have parameter LONG_CYCLES, default 25'h0A98AC7, meaning the low time of a long press in clocks; this matches the long-press detection threshold.
REQ-004 SHALL have parameter GAP_CYCLES, default 25'h04C4B40, meaning the high time between repeated presses in clocks.
REQ-005 SHALL have port FPGA_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port FPGA_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request to emit a press sequence.
REQ-008 SHALL have port long_sel, input, 1 bit: 1 selects long presses, 0 selects short presses; sampled with start.
REQ-009 SHALL have port repeat_n, input, 4 bits: number of presses; sampled with start.
REQ-010 SHALL have port abort, input, 1 bit: terminate the sequence immediately.
REQ-011 SHALL have port KEY_N, output, 1 bit: emitted key line, active-low, idle high; registered.
REQ-012 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-013 SHALL have port done, output, 1 bit: 1-cycle pulse when a sequence completes normally.
REQ-014 SHALL have port aborted, output, 1 bit: 1-cycle pulse when a sequence is terminated by abort.
REQ-015 SHALL have port press_cnt, output, 4 bits: number of presses completed in the current or last sequence.

Function
REQ-016 SHALL implement FSM states IDLE, PRESS and GAP; busy SHALL be 1 exactly when the state is not IDLE.
REQ-017 In IDLE, start=1 with abort=0 SHALL latch long_sel and repeat_n, clear press_cnt, and enter PRESS at the next edge; KEY_N SHALL go low at that same edge (latency 1 clock).
REQ-018 repeat_n=0 SHALL be treated as 1.
REQ-019 start while busy SHALL be ignored; the latched parameters SHALL NOT change mid-sequence.
REQ-020 PRESS SHALL hold KEY_N=0 for exactly D clocks, where D = LONG_CYCLES if the latched long_sel=1, else SHORT_CYCLES.
REQ-021 On leaving PRESS, press_cnt SHALL increment by 1 at the same edge that KEY_N returns high.
REQ-022 If presses remain after PRESS, the FSM SHALL enter GAP with KEY_N=1 for exactly GAP_CYCLES clocks, then return to PRESS.
REQ-023 If no presses remain after PRESS, the FSM SHALL enter IDLE; done=1 and busy=0 SHALL occur at the same edge that KEY_N returns high.
REQ-024 No gap SHALL follow the last press.
REQ-025 abort=1 in PRESS or GAP SHALL force KEY_N=1, enter IDLE and pulse aborted at the next edge; done SHALL NOT pulse and press_cnt SHALL hold its value.
REQ-026 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL be ignored, abort winning.
REQ-027 The duration counter SHALL be CNT_W bits, reload at each state entry, and never wrap.
REQ-028 A parameter value of 0 SHALL be treated as 1 clock.
REQ-029 done and aborted SHALL never both be 1, and each SHALL be exactly 1 cycle wide.

Reset
REQ-030 FPGA_rst=1 at a clock edge SHALL set: state IDLE, KEY_N=1, busy=0, done=0, aborted=0, press_cnt=0, counter=0.
REQ-031 Reset asserted mid-PRESS SHALL release KEY_N high at that edge, with no done or aborted pulse.
REQ-032 Reset SHALL take priority over start and abort.
REQ-033 KEY_N SHALL never glitch low during or after reset.

Verification (SHORT=4, LONG=10, GAP=3)
REQ-034 start=1, long_sel=0, repeat_n=1 -> KEY_N low for exactly 4 clocks from the next edge; done pulses as KEY_N rises; press_cnt=1.
REQ-035 start=1, long_sel=1, repeat_n=3 -> KEY_N pattern low 10 / high 3 / low 10 / high 3 / low 10; done after the third press; busy high for 36 clocks; press_cnt=3.
REQ-036 repeat_n=0 -> exactly one press; start re-pulsed mid-press -> ignored, sequence length unchanged.
REQ-037 abort in the 2nd clock of the second press of repeat_n=2 -> KEY_N high next edge; aborted=1, done=0, press_cnt=1.
REQ-038 FPGA_rst for 1 clock in the 5th clock of a long press -> KEY_N=1, busy=0, press_cnt=0 at that edge; start and abort together in IDLE -> no activity.
